// File: rtl/sub_pkg.sv
// Shared definitions for the subtractor family: FSM encoding and default operand width.
package sub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } sub_state_e;

   localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock, start/busy/done handshake.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   sub_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             d_bit, bo_bit;

   full_subtractor u_cell (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .bi (br_q),
      .d  (d_bit),
      .bo (bo_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      part_d  = part_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
               part_d  = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = bo_bit;
            // New difference bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
            part_d = part_q >> 1;
            part_d[WIDTH-1] = d_bit;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               diff_d  = part_d;
               bout_d  = bo_bit;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         part_q  <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         part_q  <= part_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 1, 8 and 13 against an arithmetic model.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] a_s, b_s;
   logic        bin_s;
   logic        start1, start8, start13;
   logic        busy1, done1, bout1;
   logic [0:0]  diff1;
   logic        busy8, done8, bout8;
   logic [7:0]  diff8;
   logic        busy13, done13, bout13;
   logic [12:0] diff13;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a_s[0:0]), .b(b_s[0:0]), .bin(bin_s),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
   );

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a_s[7:0]), .b(b_s[7:0]), .bin(bin_s),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(13)) u_dut13 (
      .clk(clk), .rst_n(rst_n), .start(start13), .a(a_s), .b(b_s), .bin(bin_s),
      .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {bout, diff} from plain unsigned arithmetic modulo 2^w.
   function automatic logic [13:0] ref_sub(input int w, input logic [12:0] av, input logic [12:0] bv,
                                           input logic bi);
      longint m, r;
      m = (longint'(1) << w) - 1;
      r = (longint'(av) & m) - (longint'(bv) & m) - longint'(bi);
      return {(r < 0), 13'(r & m)};
   endfunction

   function automatic logic get_done(input int w);
      case (w)
         1:       return done1;
         8:       return done8;
         default: return done13;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         1:       return busy1;
         8:       return busy8;
         default: return busy13;
      endcase
   endfunction

   function automatic logic get_bout(input int w);
      case (w)
         1:       return bout1;
         8:       return bout8;
         default: return bout13;
      endcase
   endfunction

   function automatic logic [12:0] get_diff(input int w);
      case (w)
         1:       return {12'b0, diff1};
         8:       return {5'b0, diff8};
         default: return diff13;
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         1:       start1 = v;
         8:       start8 = v;
         default: start13 = v;
      endcase
   endtask

   task automatic run_op(input int w, input logic [12:0] av, input logic [12:0] bv, input logic bi,
                         input string tag);
      logic [13:0] r;
      int          n, busy_bad;
      r = ref_sub(w, av, bv, bi);
      a_s = av; b_s = bv; bin_s = bi;
      set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      a_s = 13'($urandom); b_s = 13'($urandom); bin_s = 1'($urandom);
      n = 0; busy_bad = 0;
      while (!get_done(w) && n < 4 * w + 8) begin
         if (!get_busy(w)) busy_bad++;
         tick();
         n++;
      end
      check_eq({tag, ".latency"}, n, w);
      check_eq({tag, ".busy_run"}, busy_bad, 0);
      check_eq({tag, ".busy_at_done"}, get_busy(w), 1'b0);
      check_eq({tag, ".diff"}, get_diff(w), r[12:0]);
      check_eq({tag, ".bout"}, get_bout(w), r[13]);
      tick();
      check_eq({tag, ".done_one_cycle"}, get_done(w), 1'b0);
   endtask

   // Start held high: accepts land every w+2 edges, done w edges after each accept.
   task automatic regress(input int w, input int ops);
      logic [13:0] q[$];
      logic [13:0] exp, last;
      int          p;
      p = w + 2;
      rst_n = 1'b0; #1; rst_n = 1'b1;
      last = '0;
      a_s = 13'($urandom); b_s = 13'($urandom); bin_s = 1'($urandom);
      set_start(w, 1'b1);
      for (int e = 0; e < ops * p; e++) begin
         if (e % p == 0) q.push_back(ref_sub(w, a_s, b_s, bin_s));
         tick();
         if (e % p == w) begin
            exp = q.pop_front();
            check_eq("rg.done", get_done(w), 1'b1);
            check_eq("rg.result", {get_bout(w), get_diff(w)}, exp);
            last = exp;
         end else begin
            check_eq("rg.no_done", get_done(w), 1'b0);
            check_eq("rg.hold", {get_bout(w), get_diff(w)}, last);
         end
         a_s = 13'($urandom); b_s = 13'($urandom); bin_s = 1'($urandom);
      end
      set_start(w, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          dones;
      logic [12:0] seen;
      logic        x, y, bi;
      rst_n = 1'b0;
      start1 = 1'b0; start8 = 1'b0; start13 = 1'b0;
      a_s = '0; b_s = '0; bin_s = 1'b0;
      #12;
      check_eq("rst.busy1", busy1, 1'b0);
      check_eq("rst.done1", done1, 1'b0);
      check_eq("rst.diff1", diff1, 1'b0);
      check_eq("rst.bout1", bout1, 1'b0);
      check_eq("rst.busy8", busy8, 1'b0);
      check_eq("rst.done8", done8, 1'b0);
      check_eq("rst.diff8", diff8, 8'h00);
      check_eq("rst.bout8", bout8, 1'b0);
      check_eq("rst.busy13", busy13, 1'b0);
      check_eq("rst.done13", done13, 1'b0);
      check_eq("rst.diff13", diff13, 13'h0);
      check_eq("rst.bout13", bout13, 1'b0);
      rst_n = 1'b1;
      tick();

      run_op(8, 13'h05, 13'h03, 1'b0, "t05_03");
      check_eq("t05_03.const", diff8, 8'h02);
      run_op(8, 13'h03, 13'h05, 1'b0, "t03_05");
      check_eq("t03_05.const", {bout8, diff8}, 9'h1FE);
      run_op(8, 13'h00, 13'h00, 1'b1, "t00_00_b");
      check_eq("t00_00_b.const", {bout8, diff8}, 9'h1FF);
      run_op(8, 13'hFF, 13'hFF, 1'b0, "tFF_FF");
      check_eq("tFF_FF.const", {bout8, diff8}, 9'h000);

      // Second start during RUN must be ignored.
      a_s = 13'h10; b_s = 13'h01; bin_s = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick();
      a_s = 13'hAA; b_s = 13'h00; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      dones = 0; seen = '0;
      for (int i = 0; i < 14; i++) begin
         if (done8) begin
            dones++;
            seen = {4'b0, bout8, diff8};
         end
         tick();
      end
      check_eq("ignore.dones", dones, 1);
      check_eq("ignore.result", seen, 13'h00F);
      check_eq("ignore.held", {bout8, diff8}, 9'h00F);

      // Reset mid-operation aborts and clears outputs.
      a_s = 13'h80; b_s = 13'h01; bin_s = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check_eq("midrst.busy", busy8, 1'b0);
      check_eq("midrst.done", done8, 1'b0);
      check_eq("midrst.diff", diff8, 8'h00);
      check_eq("midrst.bout", bout8, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) dones++;
         tick();
      end
      check_eq("midrst.no_done", dones, 0);
      check_eq("midrst.diff_after", {bout8, diff8}, 9'h000);
      run_op(8, 13'h80, 13'h01, 1'b0, "after_rst");

      // WIDTH=1 exhaustive: full-subtractor truth table.
      for (int v = 0; v < 8; v++) begin
         x = v[2]; y = v[1]; bi = v[0];
         run_op(1, {12'b0, x}, {12'b0, y}, bi, $sformatf("w1_%0d", v));
         if (!bi) begin
            check_eq($sformatf("w1_%0d.half_d", v), diff1, x ^ y);
            check_eq($sformatf("w1_%0d.half_b", v), bout1, ~x & y);
         end
      end

      run_op(13, 13'h0000, 13'h1FFF, 1'b1, "w13_edge");

      regress(8, 1000);
      regress(13, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
